// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: serves req/gnt/rvalid word reads from an internal array, plus a preload port.
// Latency: rvalid exactly READ_LATENCY cycles after the grant cycle; responses in grant order, at most one per cycle.
// Backpressure: grant withheld while MAX_OUTSTANDING reads are in flight, unless one retires this cycle; none on rvalid.
// Build option: define INSTR_RESP_RANDOM_STALL_EN to withhold grants pseudo-randomly (16-bit LFSR, ~25% of cycles).
module instr_mem_responder #(
  parameter int          DEPTH           = 1024,
  parameter int          READ_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_r_valid_o,
  output logic [31:0]              instr_r_rdata_o,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_wdata_i
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]    ERR_WORD = 32'hDEAD_BEEF;

  // Reject configurations the datapath is not built for.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_mem_responder: DEPTH must be a power of two >= 4");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("instr_mem_responder: READ_LATENCY must be 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_outstanding
    $error("instr_mem_responder: MAX_OUTSTANDING must be 1..8");
  end

  // Storage and request decode
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  word_idx;
  logic           addr_oor;
  logic [31:0]    rd_word;

  // In-flight tracking
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [CW-1:0]           out_q;
  logic                    rvalid_now;
  logic                    slot_free;
  logic                    stall;

  assign word_idx = instr_addr_i[AW+1:2];
  // Any address bit above the array span marks the fetch as out of range.
  assign addr_oor = |(instr_addr_i >> (AW + 2));
  assign rd_word  = addr_oor ? ERR_WORD : mem[word_idx];

  // A retiring response frees its slot in the same cycle, so a full block can still grant.
  assign rvalid_now  = vld_q[READ_LATENCY-1];
  assign slot_free   = (out_q < MAX_CNT) || rvalid_now;
  assign instr_gnt_o = instr_req_i && !rst && !stall && slot_free;

  assign instr_r_valid_o = vld_q[READ_LATENCY-1];
  assign instr_r_rdata_o = dat_q[READ_LATENCY-1];

`ifdef INSTR_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci feedback for x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall   = (lfsr_q[1:0] == 2'b00);

  // Free-running stall generator; only gates new grants, never in-flight responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  logic stall_seed_unused;

  assign stall             = 1'b0;
  assign stall_seed_unused = ^STALL_SEED;
`endif

  // Preload writes; a same-cycle read already sampled the old word combinationally.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Response pipeline: stage 0 captures on grant, later stages copy only valid data so rdata holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= instr_gnt_o;
      if (instr_gnt_o) begin
        dat_q[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  // Outstanding count: grant adds, retire subtracts, both together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      case ({instr_gnt_o, rvalid_now})
        2'b10:   out_q <= out_q + CW'(1);
        2'b01:   out_q <= out_q - CW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

  // The slot accounting must never overflow, and a response implies a counted grant.
  assert property (@(posedge clk) disable iff (rst) (out_q <= MAX_CNT));
  assert property (@(posedge clk) disable iff (rst) (instr_r_valid_o |-> (out_q != '0)));

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: three instances (latency 1, 3 and 2) share clock, reset and load bus.
// Expected responses are pushed at grant time and popped/compared by a scoreboard loop on each rvalid.
// Build with INSTR_RESP_RANDOM_STALL_EN defined to run the random-stall scenario instead of the exact-timing ones.
module tb_instr_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        l_we;
  logic [9:0]  l_addr;
  logic [31:0] l_wdata;

  logic        a_req, b_req, c_req;
  logic [31:0] a_addr, b_addr, c_addr;
  logic        a_gnt, b_gnt, c_gnt;
  logic        a_rvalid, b_rvalid, c_rvalid;
  logic [31:0] a_rdata, b_rdata, c_rdata;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  exp_t        sb_c[$];
  logic [31:0] shadow [16];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  instr_mem_responder #(.DEPTH(1024), .READ_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .rst(rst), .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
    .instr_r_valid_o(a_rvalid), .instr_r_rdata_o(a_rdata),
    .load_we_i(l_we), .load_addr_i(l_addr), .load_wdata_i(l_wdata));

  instr_mem_responder #(.DEPTH(1024), .READ_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst), .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
    .instr_r_valid_o(b_rvalid), .instr_r_rdata_o(b_rdata),
    .load_we_i(l_we), .load_addr_i(l_addr), .load_wdata_i(l_wdata));

  instr_mem_responder #(.DEPTH(1024), .READ_LATENCY(2), .MAX_OUTSTANDING(2)) u_c (
    .clk(clk), .rst(rst), .instr_req_i(c_req), .instr_addr_i(c_addr), .instr_gnt_o(c_gnt),
    .instr_r_valid_o(c_rvalid), .instr_r_rdata_o(c_rdata),
    .load_we_i(l_we), .load_addr_i(l_addr), .load_wdata_i(l_wdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rvalid must match the oldest expected entry in data and cycle.
  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_rvalid) begin
        total_cnt++;
        if (sb_a.size() == 0) begin
          $display("FAIL a_resp: got unexpected rvalid data=%h at cycle %0d, required no response", a_rdata, cyc);
        end else begin
          e = sb_a.pop_front();
          if (a_rdata !== e.data || cyc != e.due)
            $display("FAIL a_resp: got data=%h cycle=%0d, required data=%h cycle=%0d", a_rdata, cyc, e.data, e.due);
          else pass_cnt++;
        end
      end
      if (b_rvalid) begin
        total_cnt++;
        if (sb_b.size() == 0) begin
          $display("FAIL b_resp: got unexpected rvalid data=%h at cycle %0d, required no response", b_rdata, cyc);
        end else begin
          e = sb_b.pop_front();
          if (b_rdata !== e.data || cyc != e.due)
            $display("FAIL b_resp: got data=%h cycle=%0d, required data=%h cycle=%0d", b_rdata, cyc, e.data, e.due);
          else pass_cnt++;
        end
      end
      if (c_rvalid) begin
        total_cnt++;
        if (sb_c.size() == 0) begin
          $display("FAIL c_resp: got unexpected rvalid data=%h at cycle %0d, required no response", c_rdata, cyc);
        end else begin
          e = sb_c.pop_front();
          if (c_rdata !== e.data || cyc != e.due)
            $display("FAIL c_resp: got data=%h cycle=%0d, required data=%h cycle=%0d", c_rdata, cyc, e.data, e.due);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    step();
    l_we    = 1'b1;
    l_addr  = 10'(idx);
    l_wdata = data;
    shadow[idx] = data;
    step();
    l_we = 1'b0;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1; c_req = 1'b1;
    step();
    @(negedge clk);
    total_cnt++;
    if ({a_gnt, b_gnt, c_gnt} !== 3'b000) $display("FAIL reset_gnt: got %b, required 000", {a_gnt, b_gnt, c_gnt});
    else pass_cnt++;
    total_cnt++;
    if ({a_rvalid, b_rvalid, c_rvalid} !== 3'b000) $display("FAIL reset_rvalid: got %b, required 000", {a_rvalid, b_rvalid, c_rvalid});
    else pass_cnt++;
    total_cnt++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0 || c_rdata !== 32'h0)
      $display("FAIL reset_rdata: got %h/%h/%h, required 0", a_rdata, b_rdata, c_rdata);
    else pass_cnt++;
    total_cnt++;
    if (u_a.out_q !== '0 || u_b.out_q !== '0 || u_c.out_q !== '0)
      $display("FAIL reset_outstanding: got %0d/%0d/%0d, required 0", u_a.out_q, u_b.out_q, u_c.out_q);
    else pass_cnt++;
    step();
    rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e;
    step();
    a_req = 1'b1; a_addr = 32'h0000_0014;
    @(negedge clk);
    total_cnt++;
    if (a_gnt !== 1'b1) $display("FAIL single_gnt: got %b, required 1", a_gnt);
    else pass_cnt++;
    if (a_gnt === 1'b1) begin e.data = 32'h0000_0513; e.due = cyc + 1; sb_a.push_back(e); end
    step();
    a_req = 1'b0;
    step();
    @(negedge clk);
    total_cnt++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0000_0513)
      $display("FAIL single_hold: got rvalid=%b rdata=%h, required rvalid=0 rdata=00000513", a_rvalid, a_rdata);
    else pass_cnt++;
    for (int k = 0; k < 12 && sb_a.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_a.size() != 0) $display("FAIL single_drain: got %0d pending, required 0", sb_a.size());
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    addrs[0] = 32'h0001_0000; exps[0] = 32'hDEAD_BEEF;
    addrs[1] = 32'h8000_0014; exps[1] = 32'hDEAD_BEEF;
    addrs[2] = 32'h0000_000C; exps[2] = shadow[3];
    for (int i = 0; i < 3; i++) begin
      step();
      a_req = 1'b1; a_addr = addrs[i];
      @(negedge clk);
      total_cnt++;
      if (a_gnt !== 1'b1) $display("FAIL oor_gnt[%0d]: got %b, required 1", i, a_gnt);
      else pass_cnt++;
      if (a_gnt === 1'b1) begin e.data = exps[i]; e.due = cyc + 1; sb_a.push_back(e); end
    end
    step();
    a_req = 1'b0;
    for (int k = 0; k < 12 && sb_a.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_a.size() != 0) $display("FAIL oor_drain: got %0d pending, required 0", sb_a.size());
    else pass_cnt++;
  endtask

  task automatic test_load_collision();
    exp_t e;
    step();
    a_req = 1'b1; a_addr = 32'h0000_0008;
    l_we = 1'b1; l_addr = 10'd2; l_wdata = 32'h1111_1111;
    @(negedge clk);
    total_cnt++;
    if (a_gnt !== 1'b1) $display("FAIL collide_gnt: got %b, required 1", a_gnt);
    else pass_cnt++;
    if (a_gnt === 1'b1) begin e.data = shadow[2]; e.due = cyc + 1; sb_a.push_back(e); end
    shadow[2] = 32'h1111_1111;
    step();
    l_we = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (a_gnt !== 1'b1 || a_rvalid !== 1'b1)
      $display("FAIL back_to_back: got gnt=%b rvalid=%b, required gnt=1 rvalid=1", a_gnt, a_rvalid);
    else pass_cnt++;
    if (a_gnt === 1'b1) begin e.data = shadow[2]; e.due = cyc + 1; sb_a.push_back(e); end
    step();
    a_req = 1'b0;
    for (int k = 0; k < 12 && sb_a.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_a.size() != 0) $display("FAIL collide_drain: got %0d pending, required 0", sb_a.size());
    else pass_cnt++;
  endtask

  task automatic test_outstanding_limit();
    exp_t e;
    logic exp_gnt [4];
    int   nxt = 0;
    exp_gnt[0] = 1'b1; exp_gnt[1] = 1'b1; exp_gnt[2] = 1'b0; exp_gnt[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      b_req = 1'b1; b_addr = 32'(nxt * 4);
      @(negedge clk);
      total_cnt++;
      if (b_gnt !== exp_gnt[i]) $display("FAIL limit_gnt[%0d]: got %b, required %b", i, b_gnt, exp_gnt[i]);
      else pass_cnt++;
      if (b_gnt === 1'b1) begin
        e.data = shadow[nxt]; e.due = cyc + 3; sb_b.push_back(e);
        nxt++;
      end
    end
    step();
    b_req = 1'b0;
    for (int k = 0; k < 12 && sb_b.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_b.size() != 0) $display("FAIL limit_drain: got %0d pending, required 0", sb_b.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    exp_t e;
    step();
    c_req = 1'b1; c_addr = 32'h0000_000C;
    @(negedge clk);
    total_cnt++;
    if (c_gnt !== 1'b1) $display("FAIL inflight_gnt: got %b, required 1", c_gnt);
    else pass_cnt++;
    step();
    c_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (c_rvalid !== 1'b0) $display("FAIL inflight_discard[%0d]: got rvalid=%b, required 0", i, c_rvalid);
      else pass_cnt++;
    end
    total_cnt++;
    if (u_c.out_q !== '0) $display("FAIL inflight_outstanding: got %0d, required 0", u_c.out_q);
    else pass_cnt++;
    step();
    c_req = 1'b1; c_addr = 32'h0000_000C;
    @(negedge clk);
    total_cnt++;
    if (c_gnt !== 1'b1) $display("FAIL post_reset_gnt: got %b, required 1", c_gnt);
    else pass_cnt++;
    if (c_gnt === 1'b1) begin e.data = shadow[3]; e.due = cyc + 2; sb_c.push_back(e); end
    step();
    c_req = 1'b0;
    for (int k = 0; k < 12 && sb_c.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_c.size() != 0) $display("FAIL post_reset_drain: got %0d pending, required 0", sb_c.size());
    else pass_cnt++;
  endtask

`ifdef INSTR_RESP_RANDOM_STALL_EN
  task automatic test_random_stall();
    exp_t e;
    int gcount = 0;
    int over   = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      a_req = 1'b1; a_addr = 32'h0000_0014;
      @(negedge clk);
      if (a_gnt === 1'b1) begin
        gcount++;
        e.data = shadow[5]; e.due = cyc + 1; sb_a.push_back(e);
      end
      if (u_a.out_q > 2) over++;
    end
    step();
    a_req = 1'b0;
    total_cnt++;
    if (gcount < 700 || gcount > 800) $display("FAIL stall_gnt_count: got %0d, required 700..800", gcount);
    else pass_cnt++;
    total_cnt++;
    if (over != 0) $display("FAIL stall_outstanding: got %0d overflow cycles, required 0", over);
    else pass_cnt++;
    for (int k = 0; k < 12 && sb_a.size() != 0; k++) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_a.size() != 0) $display("FAIL stall_drain: got %0d pending, required 0", sb_a.size());
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    l_we = 1'b0; l_addr = '0; l_wdata = '0;
    a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
    a_addr = '0; b_addr = '0; c_addr = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    fork
      scoreboard();
    join_none
    test_reset();
    load_word(0, 32'h0000_0093);
    load_word(1, 32'h0010_0113);
    load_word(2, 32'h2222_2222);
    load_word(3, 32'h0030_0193);
    load_word(5, 32'h0000_0513);
`ifdef INSTR_RESP_RANDOM_STALL_EN
    test_random_stall();
`else
    test_single_read();
    test_out_of_range();
    test_load_collision();
    test_outstanding_limit();
    test_reset_inflight();
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
